mmio_io_responder: RTL and testbench



---
 rtl/mmio_io_responder.sv | 205 ++++++++++++++++++++
 tb/tb_mmio_io_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_responder.sv
//==============================================================================
// Module   : mmio_io_responder
// Purpose  : MMIO target for switches, buttons, LEDs and a 4-digit 7-seg display.
//            Optional macro SEG_SCAN_EN selects the multiplexed display scan.
// Revision : 1.0
//==============================================================================
`default_nettype none

module mmio_io_responder #(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
   parameter int          DB_CYCLES = 500000,
   parameter int          SCAN_DIV  = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr_i,
   input  logic        rd_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   input  logic [7:0]  sw_i,
   input  logic [3:0]  btn_i,
   output logic [15:0] seg_o,
   output logic [7:0]  led_o
);

   localparam int DB_W = $clog2(DB_CYCLES);

   localparam logic [5:0] c_off_sw     = 6'h00;
   localparam logic [5:0] c_off_btn    = 6'h01;
   localparam logic [5:0] c_off_edge   = 6'h02;
   localparam logic [5:0] c_off_led    = 6'h03;
   localparam logic [5:0] c_off_segval = 6'h04;
   localparam logic [5:0] c_off_segctl = 6'h05;

   logic              hit;
   logic [5:0]        off;
   logic              wr_hit;

   logic [7:0]             sw_meta_q, sw_sync_q;
   logic [3:0]             btn_meta_q, btn_sync_q;
   logic [3:0]             stable_q, stable_d;
   logic [3:0][DB_W-1:0]   cnt_q, cnt_d;
   logic [3:0]             edge_q, edge_d;
   logic [3:0]             rise, clr;
   logic [7:0]             led_q;
   logic [15:0]            segval_q;
   logic [3:0]             segctl_q;
   logic [15:0]            seg_q;

   assign hit    = (addr_i[31:8] == BASE_ADDR[31:8]);
   assign off    = addr_i[7:2];
   assign wr_hit = we_i && hit;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      for (int i = 0; i < 4; i++) begin
         if (btn_sync_q[i] != stable_q[i]) begin
            if (cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
               stable_d[i] = btn_sync_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // A rise landing in the same cycle as a clear keeps the flag set.
   assign rise = stable_d & ~stable_q;
   always_comb begin
      clr = 4'h0;
      if (rd_i && hit && off == c_off_edge) begin
         clr = clr | edge_q;
      end
      if (wr_hit && off == c_off_edge && be_i[0]) begin
         clr = clr | wdata_i[3:0];
      end
      edge_d = (edge_q & ~clr) | rise;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         btn_meta_q <= '0;
         btn_sync_q <= '0;
         stable_q   <= '0;
         cnt_q      <= '0;
         edge_q     <= '0;
         led_q      <= '0;
         segval_q   <= '0;
         segctl_q   <= '0;
      end else begin
         sw_meta_q  <= sw_i;
         sw_sync_q  <= sw_meta_q;
         btn_meta_q <= btn_i;
         btn_sync_q <= btn_meta_q;
         stable_q   <= stable_d;
         cnt_q      <= cnt_d;
         edge_q     <= edge_d;
         if (wr_hit && off == c_off_led && be_i[0]) begin
            led_q <= wdata_i[7:0];
         end
         if (wr_hit && off == c_off_segval) begin
            if (be_i[0]) segval_q[7:0]  <= wdata_i[7:0];
            if (be_i[1]) segval_q[15:8] <= wdata_i[15:8];
         end
         if (wr_hit && off == c_off_segctl && be_i[0]) begin
            segctl_q <= wdata_i[3:0];
         end
      end
   end

   always_comb begin
      rdata_o = 32'h0;
      if (hit) begin
         case (off)
            c_off_sw:     rdata_o = {24'h0, sw_sync_q};
            c_off_btn:    rdata_o = {28'h0, stable_q};
            c_off_edge:   rdata_o = {28'h0, edge_q};
            c_off_led:    rdata_o = {24'h0, led_q};
            c_off_segval: rdata_o = {16'h0, segval_q};
            c_off_segctl: rdata_o = {28'h0, segctl_q};
            default:      rdata_o = 32'h0;
         endcase
      end
   end

`ifdef SEG_SCAN_EN
   localparam int PRE_W = $clog2(SCAN_DIV);

   logic [PRE_W-1:0] pre_q;
   logic [1:0]       dig_q;
   logic [15:0]      seg_d;
   logic [3:0]       nib;

   function automatic logic [7:0] glyph(input logic [3:0] v);
      case (v)
         4'h0: glyph = 8'hC0;
         4'h1: glyph = 8'hF9;
         4'h2: glyph = 8'hA4;
         4'h3: glyph = 8'hB0;
         4'h4: glyph = 8'h99;
         4'h5: glyph = 8'h92;
         4'h6: glyph = 8'h82;
         4'h7: glyph = 8'hF8;
         4'h8: glyph = 8'h80;
         4'h9: glyph = 8'h90;
         4'hA: glyph = 8'h88;
         4'hB: glyph = 8'h83;
         4'hC: glyph = 8'hC6;
         4'hD: glyph = 8'hA1;
         4'hE: glyph = 8'h86;
         default: glyph = 8'h8E;
      endcase
   endfunction

   always_comb begin
      nib = segval_q[{dig_q, 2'b00} +: 4];
      if (segctl_q[dig_q]) begin
         seg_d = 16'h0FFF;
      end else begin
         seg_d = {4'h0, ~(4'b0001 << dig_q), glyph(nib)};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_q <= '0;
         dig_q <= '0;
         seg_q <= 16'h0FFF;
      end else begin
         seg_q <= seg_d;
         if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_q <= '0;
            dig_q <= dig_q + 2'd1;
         end else begin
            pre_q <= pre_q + 1'b1;
         end
      end
   end

   logic unused_bits;
   assign unused_bits = ^{addr_i[1:0], wdata_i[31:16], be_i[3:2]};
`else
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_q <= 16'h0000;
      end else begin
         seg_q <= segval_q;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{addr_i[1:0], wdata_i[31:16], be_i[3:2], 1'(SCAN_DIV)};
`endif

   assign seg_o = seg_q;
   assign led_o = led_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_io_responder.sv
// Scoreboard bench for mmio_io_responder (DB_CYCLES=4, SCAN_DIV=4).
`default_nettype none

module tb_mmio_io_responder;

   localparam logic [31:0] BASE = 32'hFFFF_FF00;

`ifdef SEG_SCAN_EN
   localparam logic [15:0] SEG_RST = 16'h0FFF;
`else
   localparam logic [15:0] SEG_RST = 16'h0000;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr;
   logic        rd;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  sw;
   logic [3:0]  btn;
   logic [15:0] seg;
   logic [7:0]  led;

   mmio_io_responder #(
      .BASE_ADDR (BASE),
      .DB_CYCLES (4),
      .SCAN_DIV  (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .addr_i  (addr),
      .rd_i    (rd),
      .we_i    (we),
      .be_i    (be),
      .wdata_i (wdata),
      .rdata_o (rdata),
      .sw_i    (sw),
      .btn_i   (btn),
      .seg_o   (seg),
      .led_o   (led)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   // kind 0: rdata, 1: led pins, 2: seg pins
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      while (q.size() > 0) begin
         e = q.pop_front();
         case (e.kind)
            0:       act = rdata;
            1:       act = {24'h0, led};
            default: act = {16'h0, seg};
         endcase
         checks++;
         if (act !== e.val) begin
            failures++;
            $display("FAIL %s: got %h required %h", e.name, act, e.val);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      rd    = 1'b0;
      we    = 1'b0;
      be    = 4'h0;
      wdata = 32'h0;
      addr  = 32'h0;
   endtask

   task automatic rd_chk(input logic [7:0] off, input logic [31:0] val, input string nm);
      addr = BASE | {24'h0, off};
      rd   = 1'b1;
      q.push_back('{0, nm, val});
   endtask

   task automatic wr(input logic [7:0] off, input logic [3:0] b, input logic [31:0] d);
      addr  = BASE | {24'h0, off};
      we    = 1'b1;
      be    = b;
      wdata = d;
   endtask

   task automatic obs(input int k, input logic [31:0] val, input string nm);
      q.push_back('{k, nm, val});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] scan_exp [4];
      logic [15:0] blank_exp [5];
`ifdef SEG_SCAN_EN
      scan_exp  = '{16'h0DB0, 16'h0BA4, 16'h07F9, 16'h0E99};
      blank_exp = '{16'h0DB0, 16'h0DB0, 16'h0FFF, 16'h0FFF, 16'h0BA4};
`else
      scan_exp  = '{16'h1234, 16'h1234, 16'h1234, 16'h1234};
      blank_exp = '{16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
`endif
      rst_n = 1'b0; addr = '0; rd = 1'b0; we = 1'b0; be = '0; wdata = '0;
      sw = '0; btn = '0;

      tick(); obs(1, 32'h0, "rst_led"); obs(2, {16'h0, SEG_RST}, "rst_seg");
      tick(); rd_chk(8'h04, 32'h0, "rst_btn");
      tick(); rst_n = 1'b1; rd_chk(8'h08, 32'h0, "rst_edge");
      tick(); rd_chk(8'h0C, 32'h0, "rst_led_reg");
      tick(); rd_chk(8'h10, 32'h0, "rst_segval");
      tick(); rd_chk(8'h14, 32'h0, "rst_segctl");

      // Accesses outside the window
      tick(); addr = 32'h0000_0010; we = 1'b1; be = 4'hF; wdata = 32'hFFFF_FFFF; rd = 1'b1;
      q.push_back('{0, "miss_rd_segval", 32'h0});
      tick(); addr = 32'h0000_000C; we = 1'b1; be = 4'h1; wdata = 32'hFF; rd = 1'b1;
      q.push_back('{0, "miss_rd_led", 32'h0});
      tick(); rd_chk(8'h0C, 32'h0, "led_after_miss"); obs(1, 32'h0, "led_pin_after_miss");
      tick(); rd_chk(8'h10, 32'h0, "segval_after_miss");
      tick(); rd_chk(8'h18, 32'h0, "unmapped_rd");

      // Switch synchroniser latency
      tick(); sw = 8'hA5; rd_chk(8'h00, 32'h0, "sw_edge0");
      tick(); rd_chk(8'h00, 32'h0, "sw_edge1");
      tick(); rd_chk(8'h00, 32'hA5, "sw_edge2");

      // LED lanes and read-during-write
      tick(); wr(8'h0C, 4'b0001, 32'h0000_003C);
      tick(); obs(1, 32'h3C, "led_store"); wr(8'h0C, 4'b0010, 32'h0000_FF00);
      tick(); obs(1, 32'h3C, "led_lane1_ignored"); rd_chk(8'h0C, 32'h3C, "led_rd");
      tick(); wr(8'h0C, 4'b0001, 32'h55); rd = 1'b1; q.push_back('{0, "led_rw_old", 32'h3C});
      tick(); rd_chk(8'h0C, 32'h55, "led_rw_new");

      // SEGVAL / SEGCTL lanes
      tick(); wr(8'h10, 4'b0001, 32'hABCD_EF12);
      tick(); rd_chk(8'h10, 32'h12, "segval_lane0");
      tick(); wr(8'h10, 4'b1110, 32'h1234_5678);
      tick(); rd_chk(8'h10, 32'h5612, "segval_lane1");
      tick(); wr(8'h14, 4'b0001, 32'hFF);
      tick(); rd_chk(8'h14, 32'hF, "segctl_rw");
      tick(); wr(8'h14, 4'b0001, 32'h0);

      // Button glitch of 3 cycles is rejected
      tick(); btn = 4'b0010;
      repeat (2) tick();
      tick(); btn = 4'b0000;
      repeat (4) tick();
      tick(); rd_chk(8'h04, 32'h0, "glitch_btn");
      tick(); rd_chk(8'h08, 32'h0, "glitch_edge");

      // Held press: stable rises 6 edges after the button goes high
      tick(); btn = 4'b0010;
      repeat (9) tick();
      tick(); btn = 4'b0000; rd_chk(8'h04, 32'h2, "press_btn");
      tick(); rd_chk(8'h08, 32'h2, "press_edge");
      tick(); rd_chk(8'h08, 32'h0, "edge_clear_on_read");
      repeat (5) tick();
      tick(); rd_chk(8'h04, 32'h0, "release_btn");
      tick(); rd_chk(8'h08, 32'h0, "release_no_edge");

      // Clear-on-read coinciding with a new rise of stable[0]
      tick(); btn = 4'b0001;
      repeat (5) tick();
      tick(); btn = 4'b0000;
      repeat (7) tick();
      tick(); btn = 4'b0001;
      repeat (4) tick();
      tick(); rd_chk(8'h08, 32'h1, "edge_read_at_rise");
      tick(); wr(8'h08, 4'b0000, 32'h1);
      tick(); wr(8'h08, 4'b0001, 32'hE);
      tick(); rd_chk(8'h08, 32'h1, "edge_set_wins");

      // Multiple buttons and write-1-to-clear
      tick(); btn = 4'b1101;
      repeat (6) tick();
      tick(); wr(8'h08, 4'b0001, 32'h8);
      tick(); rd_chk(8'h04, 32'hD, "btn_multi");
      tick(); rd_chk(8'h08, 32'h4, "w1c_edge");

      // Reset mid-operation, then display behaviour from a known phase
      tick(); rst_n = 1'b0; btn = 4'b0000;
      tick(); obs(1, 32'h0, "rst2_led"); obs(2, {16'h0, SEG_RST}, "rst2_seg");
      tick(); rst_n = 1'b1; wr(8'h10, 4'b0011, 32'h0000_1234);
`ifdef SEG_SCAN_EN
      tick(); rd_chk(8'h04, 32'h0, "rst2_btn");
      tick(); rd_chk(8'h08, 32'h0, "rst2_edge");
`else
      tick(); rd_chk(8'h04, 32'h0, "rst2_btn"); obs(2, 32'h0, "seg_lag");
      tick(); rd_chk(8'h08, 32'h0, "rst2_edge"); obs(2, 32'h1234, "seg_reg");
`endif
      tick(); rd_chk(8'h0C, 32'h0, "rst2_led_reg");
      tick(); rd_chk(8'h10, 32'h1234, "segval_rd");
      for (int k = 0; k < 16; k++) begin
         tick(); obs(2, {16'h0, scan_exp[k / 4]}, "seg_scan");
      end
      tick(); wr(8'h14, 4'b0001, 32'h2); obs(2, {16'h0, blank_exp[0]}, "seg_blank0");
      for (int k = 1; k < 5; k++) begin
         tick(); obs(2, {16'h0, blank_exp[k]}, "seg_blank");
      end

      tick();
      tick();
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
